sio_rx_fifo: RTL and testbench

SIO_RX_FIFO -- requirements
Module: sio_rx_fifo

---
 rtl/sio_rx_fifo.sv | 211 +++++++++++++++++++++
 tb/tb_sio_rx_fifo.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/sio_rx_fifo.sv
// Serial 8N1 receiver feeding a show-ahead byte FIFO with sticky overrun/frame error flags.
// Latency: byte pushed the cycle after the mid-stop-bit sample, visible on data one edge later.
// Backpressure: none on the serial side; a push into a full FIFO with no pop is dropped and flagged.
module sio_rx_fifo #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int DEPTH_LOG2   = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  rx,
    input  logic                  rd,
    input  logic                  clr_err,
    output logic [7:0]            data,
    output logic                  rx_valid,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overrun,
    output logic                  frame_err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int TW    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    // Timer reload values: half a bit to land in the middle of the start bit, then whole bits.
    localparam logic [TW-1:0]         T_HALF   = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0]         T_FULL   = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0]         T_ONE    = TW'(1);
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_DATA    = 3'd2,
        S_STOP    = 3'd3,
        S_WAIT_HI = 3'd4
    } state_t;

    // Synchronizer
    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic rx_s;

    // Receiver
    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            push_q, push_d;
    logic            tick;
    logic            ferr_set;

    // FIFO
    logic [7:0]            mem_q [DEPTH];
    logic [7:0]            mem_d [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  overrun_q, overrun_d;
    logic                  frame_err_q, frame_err_d;
    logic                  do_pop;
    logic                  do_wr;
    logic                  ovr_set;
    logic                  full;

    // Two-flop synchronizer on the asynchronous serial input, idling high.
    always_comb begin
        sync1_d = rx;
        sync2_d = sync1_q;
    end

    assign rx_s = sync2_q;
    assign tick = (timer_q == '0);

    // State and datapath registers; reset discards any partial frame and all queued bytes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            state_q     <= S_IDLE;
            timer_q     <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            push_q      <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            state_q     <= state_d;
            timer_q     <= timer_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            push_q      <= push_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Receiver next-state: each bit is sampled in the cycle the timer reaches zero.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!rx_s) state_d = S_START;
            end
            S_START: begin
                if (tick) state_d = rx_s ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (tick && (bit_idx_q == 3'd7)) state_d = S_STOP;
            end
            S_STOP: begin
                if (tick) state_d = rx_s ? S_IDLE : S_WAIT_HI;
            end
            S_WAIT_HI: begin
                // Stay here through a break so it produces a single frame error.
                if (rx_s) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Receiver outputs: timer reloads, LSB-first shifting, push request and frame error event.
    always_comb begin
        timer_d   = tick ? timer_q : (timer_q - T_ONE);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        push_d    = 1'b0;
        ferr_set  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!rx_s) timer_d = T_HALF;
            end
            S_START: begin
                if (tick && !rx_s) begin
                    timer_d   = T_FULL;
                    bit_idx_d = 3'd0;
                end
            end
            S_DATA: begin
                if (tick) begin
                    shift_d   = {rx_s, shift_q[7:1]};
                    timer_d   = T_FULL;
                    bit_idx_d = bit_idx_q + 3'd1;
                end
            end
            S_STOP: begin
                if (tick) begin
                    push_d   = rx_s;
                    ferr_set = !rx_s;
                end
            end
            default: ;
        endcase
    end

    // FIFO update: a pop frees a slot in the same cycle, so a simultaneous push into a full FIFO lands.
    always_comb begin
        full     = (count_q == CNT_FULL);
        do_pop   = rd && (count_q != '0);
        do_wr    = push_q && (!full || do_pop);
        ovr_set  = push_q && full && !do_pop;

        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        // The shift register is untouched until the next frame's data bits, so it still holds the byte.
        if (do_wr) begin
            mem_d[wr_ptr_q] = shift_q;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({do_wr, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Sticky error flags: a set event in the same cycle as clr_err wins.
    always_comb begin
        overrun_d   = ovr_set  ? 1'b1 : (clr_err ? 1'b0 : overrun_q);
        frame_err_d = ferr_set ? 1'b1 : (clr_err ? 1'b0 : frame_err_q);
    end

    assign data      = mem_q[rd_ptr_q];
    assign rx_valid  = (count_q != '0);
    assign count     = count_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_sio_rx_fifo.sv
// Bench for sio_rx_fifo: drives 8N1 frames and checks popped bytes against a scoreboard queue.
// Latency: bytes are expected to be readable once the frame's stop bit has been driven.
// Backpressure: the bench pops only when its model says data is held.
module tb_sio_rx_fifo;

    localparam int CPB = 16;

    logic       clk;
    logic       reset_n;
    logic       rx;
    logic       rd;
    logic       clr_err;
    logic [7:0] data;
    logic       rx_valid;
    logic [4:0] count;
    logic       overrun;
    logic       frame_err;

    int         checks;
    int         errors;
    logic [7:0] exp_q[$];
    logic       seen;

    sio_rx_fifo #(
        .CLKS_PER_BIT (CPB),
        .DEPTH_LOG2   (4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rx        (rx),
        .rd        (rd),
        .clr_err   (clr_err),
        .data      (data),
        .rx_valid  (rx_valid),
        .count     (count),
        .overrun   (overrun),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Hold rx at a level for one bit time; entered and left at posedge+1.
    task automatic drive_bit(input logic v);
        rx = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
        rx = 1'b1;
    endtask

    // Send a good frame and record what the FIFO should do with it.
    task automatic send_model(input logic [7:0] b);
        send_byte(b, 1'b1);
        if (exp_q.size() < 16) exp_q.push_back(b);
    endtask

    task automatic pop_chk(input string tag);
        logic [7:0] e;
        check({tag, "_vld"}, {31'd0, rx_valid}, 32'd1);
        e = exp_q.pop_front();
        check({tag, "_dat"}, {24'd0, data}, {24'd0, e});
        rd = 1'b1;
        @(posedge clk);
        #1;
        rd = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(posedge clk);
        #1;
        clr_err = 1'b0;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        seen    = 1'b0;
        reset_n = 1'b0;
        rx      = 1'b1;
        rd      = 1'b0;
        clr_err = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_count", {27'd0, count}, 32'd0);
        check("rst_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_data", {24'd0, data}, 32'h00);
        check("rst_ovr", {31'd0, overrun}, 32'd0);
        check("rst_ferr", {31'd0, frame_err}, 32'd0);
        reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Two bytes in order, show-ahead pops
        send_model(8'h55);
        send_model(8'hA3);
        check("two_count", {27'd0, count}, 32'd2);
        pop_chk("two_pop0");
        check("two_count1", {27'd0, count}, 32'd1);
        pop_chk("two_pop1");
        check("two_empty", {31'd0, rx_valid}, 32'd0);

        // Short low glitch must be rejected
        rx = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("glitch_count", {27'd0, count}, 32'd0);
        check("glitch_ferr", {31'd0, frame_err}, 32'd0);
        check("glitch_ovr", {31'd0, overrun}, 32'd0);

        // 17 bytes without popping: the last one is dropped
        for (int i = 0; i < 17; i++) send_model(8'(i));
        check("full_count", {27'd0, count}, 32'd16);
        check("full_ovr", {31'd0, overrun}, 32'd1);
        for (int i = 0; i < 16; i++) pop_chk($sformatf("full_pop%0d", i));
        check("full_drained", {31'd0, rx_valid}, 32'd0);
        pulse_clr();
        check("ovr_cleared", {31'd0, overrun}, 32'd0);

        // Bad stop bit followed by a break, then a good frame
        send_byte(8'h3C, 1'b0);
        rx = 1'b0;
        repeat (3 * CPB) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (2 * CPB) @(posedge clk);
        #1;
        send_model(8'h7E);
        check("ferr_set", {31'd0, frame_err}, 32'd1);
        check("ferr_count", {27'd0, count}, 32'd1);
        pop_chk("ferr_pop");
        check("ferr_empty", {31'd0, rx_valid}, 32'd0);
        pulse_clr();
        check("ferr_cleared", {31'd0, frame_err}, 32'd0);

        // Full FIFO, pop in the exact cycle of the 17th push
        for (int i = 0; i < 16; i++) send_model(8'h80 + 8'(i));
        check("sim_full_count", {27'd0, count}, 32'd16);
        seen = 1'b0;
        fork
            send_byte(8'h99, 1'b1);
            begin
                for (int i = 0; i < 400 && !seen; i++) begin
                    @(posedge clk);
                    #1;
                    if (dut.push_q) begin
                        logic [7:0] e;
                        seen = 1'b1;
                        e = exp_q.pop_front();
                        check("sim_head", {24'd0, data}, {24'd0, e});
                        exp_q.push_back(8'h99);
                        rd = 1'b1;
                        @(posedge clk);
                        #1;
                        rd = 1'b0;
                    end
                end
            end
        join
        check("sim_push_seen", {31'd0, seen}, 32'd1);
        check("sim_count", {27'd0, count}, 32'd16);
        check("sim_ovr", {31'd0, overrun}, 32'd0);
        while (exp_q.size() > 0) pop_chk("sim_pop");
        check("sim_empty", {31'd0, rx_valid}, 32'd0);

        // Asynchronous reset mid-frame with bytes queued
        send_model(8'h11);
        send_model(8'h22);
        send_model(8'h33);
        check("mid_count", {27'd0, count}, 32'd3);
        fork
            send_byte(8'h5A, 1'b1);
        join_none
        repeat (40) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("arst_count", {27'd0, count}, 32'd0);
        check("arst_valid", {31'd0, rx_valid}, 32'd0);
        check("arst_data", {24'd0, data}, 32'h00);
        wait fork;
        exp_q.delete();
        reset_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        send_model(8'h42);
        check("post_count", {27'd0, count}, 32'd1);
        check("post_ferr", {31'd0, frame_err}, 32'd0);
        pop_chk("post_pop");
        check("post_empty", {31'd0, rx_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
